// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a shared tristate data bus.
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    grant_valid_s;
  logic                    grant_s;
  logic                    accept_s;
  logic                    acc_wr_s;
  logic [ADDR_WIDTH-1:0]   acc_addr_s;
  logic [DATA_WIDTH-1:0]   acc_wdata_s;
  logic                    owner_r;
  logic                    wr_en_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    rsp0_valid_r;
  logic                    rsp1_valid_r;
  logic [DATA_WIDTH-1:0]   rsp0_rdata_r;
  logic [DATA_WIDTH-1:0]   rsp1_rdata_r;
`ifdef RAM_ARB_FIXED_PRIO_EN
`else
  logic                    ptr_r;
`endif

  // Arbitration: a lone requester always wins; contention goes to the priority holder.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
      grant_s       = 1'b0;
`else
      grant_s       = ptr_r;
`endif
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  assign acc_wr_s    = grant_s ? req1_wr    : req0_wr;
  assign acc_addr_s  = grant_s ? req1_addr  : req0_addr;
  assign acc_wdata_s = grant_s ? req1_wdata : req0_wdata;

  // Next-state logic; every access is one cycle long and returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          accept_s     = 1'b1;
          state_next_s = acc_wr_s ? WRITE : READ;
        end else begin
          accept_s     = 1'b0;
          state_next_s = IDLE;
        end
      end
      WRITE:   state_next_s = IDLE;
      READ:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch; write enable is registered so the bus is driven only in WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_r <= 1'b0;
      wr_en_r <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
`ifdef RAM_ARB_FIXED_PRIO_EN
`else
      ptr_r   <= 1'b0;
`endif
    end else begin
      wr_en_r <= accept_s && acc_wr_s;
      if (accept_s) begin
        owner_r <= grant_s;
        addr_r  <= acc_addr_s;
        wdata_r <= acc_wdata_s;
`ifdef RAM_ARB_FIXED_PRIO_EN
`else
        ptr_r   <= ~grant_s;
`endif
      end
    end
  end

  // Completion pulse and read-data capture at the edge ending the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp1_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp0_valid_r <= (state_r == WRITE || state_r == READ) && (owner_r == 1'b0);
      rsp1_valid_r <= (state_r == WRITE || state_r == READ) && (owner_r == 1'b1);
      if (state_r == READ && owner_r == 1'b0) rsp0_rdata_r <= ram_data;
      if (state_r == READ && owner_r == 1'b1) rsp1_rdata_r <= ram_data;
    end
  end

  assign req0_ready = rst_n && accept_s && (grant_s == 1'b0);
  assign req1_ready = rst_n && accept_s && (grant_s == 1'b1);
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_rdata = rsp0_rdata_r;
  assign rsp1_rdata = rsp1_rdata_r;
  assign ram_addr   = addr_r;
  assign ram_wr_en  = wr_en_r;
  assign ram_data   = wr_en_r ? wdata_r : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; honours RAM_ARB_FIXED_PRIO_EN.
module tb_ram_arbiter;

  localparam logic [15:0] PROBE = 16'h5A3C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v [2];
  logic        wr [2];
  logic [3:0]  addr [2];
  logic [15:0] wdata [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_wr_en;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic [3:0]  ram_addr;
  wire  [15:0] ram_data;

  // environment: RAM (or a fixed probe value when "disconnected")
  logic [15:0] mem [16] = '{default: 16'h0000};
  logic        ram_connected = 1'b1;
  assign ram_data = ram_wr_en ? 16'hzzzz : (ram_connected ? mem[ram_addr] : PROBE);
  always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_data;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_wr(wr[0]), .req0_addr(addr[0]), .req0_wdata(wdata[0]),
    .req1_valid(v[1]), .req1_wr(wr[1]), .req1_addr(addr[1]), .req1_wdata(wdata[1]),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_data(ram_data)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one outstanding access, a priority pointer, expected memory
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  bit          m_wr = 1'b0;
  logic [3:0]  m_addr = 4'h0;
  logic [15:0] m_wdata = 16'h0000;
  int          m_ptr = 0;
  bit          m_rv [2] = '{1'b0, 1'b0};
  logic [15:0] m_rd [2] = '{16'h0000, 16'h0000};
  logic [3:0]  m_last_addr = 4'h0;
  logic [15:0] exp_mem [16] = '{default: 16'h0000};
  bit          m_acc [2] = '{1'b0, 1'b0};
  int          dut_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int winner();
    if (!rst_n || m_busy) return -1;
    if (v[0] && v[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return m_ptr;
`endif
    end
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic check_all();
    int g;
    bit exp_we;
    logic [15:0] env;
    g = winner();
    exp_we = m_busy && m_wr;
    env = ram_connected ? mem[ram_addr] : PROBE;
    chk("ready0", req0_ready, (g == 0));
    chk("ready1", req1_ready, (g == 1));
    chk("rsp0_valid", rsp0_valid, m_rv[0]);
    chk("rsp1_valid", rsp1_valid, m_rv[1]);
    chk("rsp0_rdata", rsp0_rdata, m_rd[0]);
    chk("rsp1_rdata", rsp1_rdata, m_rd[1]);
    chk("ram_wr_en", ram_wr_en, exp_we);
    chk("ram_addr", ram_addr, m_last_addr);
    chk("ram_data", ram_data, exp_we ? m_wdata : env);
    if (req0_ready && v[0]) dut_log.push_back(0);
    else if (req1_ready && v[1]) dut_log.push_back(1);
  endtask

  task automatic model_edge();
    int g;
    g = winner();
    m_acc[0] = 1'b0;
    m_acc[1] = 1'b0;
    if (!rst_n) begin
      if (m_busy && m_wr) exp_mem[m_addr] = m_wdata;
      m_busy = 1'b0; m_ptr = 0; m_last_addr = 4'h0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 16'h0000; m_rd[1] = 16'h0000;
    end else if (m_busy) begin
      m_rv[0] = (m_owner == 0); m_rv[1] = (m_owner == 1);
      if (m_wr) exp_mem[m_addr] = m_wdata;
      else m_rd[m_owner] = ram_connected ? exp_mem[m_addr] : PROBE;
      m_busy = 1'b0;
    end else begin
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (g >= 0) begin
        m_busy = 1'b1; m_owner = g; m_wr = wr[g]; m_addr = addr[g]; m_wdata = wdata[g];
        m_last_addr = addr[g];
        m_acc[g] = 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
        m_ptr = 1 - g;
`endif
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input int k, input bit w, input logic [3:0] a, input logic [15:0] d);
    bit got;
    got = 1'b0;
    v[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = m_acc[k];
    end
    chk("issue_accept", got, 1'b1);
    v[k] = 1'b0;
  endtask

  initial begin
    int exp_k;
    rst_n = 1'b0;
    v[0] = 1'b1; v[1] = 1'b1; wr[0] = 1'b1; wr[1] = 1'b0;
    addr[0] = 4'h7; addr[1] = 4'h9; wdata[0] = 16'h1234; wdata[1] = 16'h4321;

    // reset held 2 cycles with both requesters valid
    cycle(); cycle();
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_wr_en", ram_wr_en, 1'b0);
    chk("rst_addr", ram_addr, 4'h0);
    v[0] = 1'b0; v[1] = 1'b0;
    rst_n = 1'b1;
    cycle();

    // req0 write then read of address 3
    issue(0, 1'b1, 4'h3, 16'hA5A5);
    cycle();
    issue(0, 1'b0, 4'h3, 16'h0000);
    cycle();
    chk("rsp0_valid_after_read", rsp0_valid, 1'b1);
    chk("rsp0_rdata_a5a5", rsp0_rdata, 16'hA5A5);
    chk("rsp1_quiet", rsp1_valid, 1'b0);
    chk("mem3", mem[3], 16'hA5A5);

    // contention: both read continuously from a fresh pointer
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    dut_log.delete();
    v[0] = 1'b1; v[1] = 1'b1; wr[0] = 1'b0; wr[1] = 1'b0; addr[0] = 4'h3; addr[1] = 4'h5;
    for (int i = 0; i < 9; i++) cycle();
    v[0] = 1'b0; v[1] = 1'b0;
    chk("contention_count", dut_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_k = 0;
`else
      exp_k = i % 2;
`endif
      chk("contention_order", dut_log[i], exp_k);
    end
    cycle();

    // req1 fills all addresses then reads them back
    for (int a = 0; a < 16; a++) issue(1, 1'b1, 4'(a), 16'(a * 16'h1111));
    for (int a = 0; a < 16; a++) issue(1, 1'b0, 4'(a), 16'h0000);
    cycle();
    chk("rsp1_last_read", rsp1_rdata, 16'hFFFF);

    // reset at the edge ending a req1 read
    issue(1, 1'b0, 4'h2, 16'h0000);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("abort_rsp1_valid", rsp1_valid, 1'b0);
    chk("abort_rsp1_rdata", rsp1_rdata, 16'h0000);
    issue(1, 1'b0, 4'h2, 16'h0000);
    cycle();
    chk("post_abort_rdata", rsp1_rdata, 16'h2222);

    // bus ownership with the RAM replaced by a probe driver
    ram_connected = 1'b0;
    issue(0, 1'b1, 4'h6, 16'h00FF);
    issue(0, 1'b0, 4'h6, 16'h0000);
    cycle(); cycle();
    chk("probe_rdata", rsp0_rdata, PROBE);
    ram_connected = 1'b1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_acc[k]) v[k] = 1'b0;
        if (!v[k] && $urandom_range(0, 1) == 1) begin
          v[k] = 1'b1; wr[k] = 1'($urandom_range(0, 1));
          addr[k] = 4'($urandom_range(0, 15)); wdata[k] = 16'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 59) != 0);
      cycle();
    end
    rst_n = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    cycle(); cycle();
    for (int a = 0; a < 16; a++) chk("final_mem", mem[a], exp_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of data words and of the shared RAM data bus.
REQ-002 Parameter: ADDR_WIDTH, 4, RAM address width (depth 2**ADDR_WIDTH).
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req0_valid / req1_valid  input  1  requester k has a pending access.
REQ-007 req0_wr / req1_wr  input  1  1 = write, 0 = read.
REQ-008 req0_addr / req1_addr  input  ADDR_WIDTH  access address.
REQ-009 req0_wdata / req1_wdata  input  DATA_WIDTH  write data.
REQ-010 req0_ready / req1_ready  output  1  request accepted this cycle when valid and ready are both high.
REQ-011 rsp0_valid / rsp1_valid  output  1  one-cycle completion pulse to requester k.
REQ-012 rsp0_rdata / rsp1_rdata  output  DATA_WIDTH  read data; valid with rsp_valid after a read.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_wr_en  output  1  RAM write enable; RAM writes on rising clk when high.
REQ-015 ram_data  inout  DATA_WIDTH  shared bidirectional bus; the arbiter drives it when writing, the RAM drives it (asynchronous read) otherwise.

Function
REQ-016 States: IDLE, WRITE, READ; state is registered.
REQ-017 IDLE: ready is combinational; only the arbitration winner among valid requesters sees ready=1; the loser and non-valid requesters see 0; no valid requesters -> both ready 0.
REQ-018 Arbitration: round-robin, 1-bit priority pointer; on contention the pointed-to requester wins; after any acceptance the pointer moves to the other requester; a lone valid requester always wins.
REQ-019 On acceptance: latch owner, wr, addr, wdata; go to WRITE if wr=1 else READ; ready is 0 in WRITE and READ.
REQ-020 WRITE (1 cycle): ram_wr_en=1, ram_addr=latched addr, ram_data driven with latched wdata; RAM commits at the edge ending WRITE; next state IDLE.
REQ-021 READ (1 cycle): ram_wr_en=0, ram_addr=latched addr, ram_data high-Z from arbiter; ram_data sampled into owner's rsp_rdata at the edge ending READ; next state IDLE.
REQ-022 Response: owner's rsp_valid high for exactly the one cycle following WRITE/READ; other requester's rsp_valid stays 0; rsp_rdata unchanged after writes, holds the last read value until the next read.
REQ-023 Timing: accept at edge N, RAM access in cycle N..N+1, rsp_valid high in cycle N+1..N+2; peak throughput one access per 2 cycles; a new acceptance may occur in the rsp_valid cycle.
REQ-024 IDLE outputs: ram_wr_en=0, ram_data high-Z, ram_addr holds last value.
REQ-025 The arbiter shall never drive ram_data outside WRITE (no bus contention with the RAM).
REQ-026 Requests not accepted are not latched; requesters hold req fields stable until accepted.

Reset
REQ-027 rst_n=0 sampled at an edge: state IDLE, pointer 0, ram_addr 0, ram_wr_en 0, ram_data high-Z, rsp*_valid 0, rsp*_rdata 0; both ready 0 while rst_n=0.
REQ-028 Reset mid-operation: the in-flight access is aborted without rsp_valid; a WRITE coinciding with the reset edge still commits in the RAM (ram_wr_en sampled high at that edge); a READ result is discarded.

Configuration
REQ-029 Macro RAM_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins contention, pointer not implemented.
REQ-030 Macro undefined: round-robin per REQ-018.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with both valid=1 -> ready 0/0, rsp_valid 0/0, ram_wr_en 0, ram_addr 0, ram_data Z.
REQ-032 req0 write addr 3 data 16'hA5A5, then req0 read addr 3 -> RAM location 3 = 16'hA5A5; rsp0_rdata = 16'hA5A5 with rsp0_valid 2 cycles after read acceptance; rsp1_valid stays 0.
REQ-033 Both valid continuously, reads -> acceptances alternate 0,1,0,1 starting with 0; with RAM_ARB_FIXED_PRIO_EN all acceptances go to 0.
REQ-034 req1 writes all 16 addresses with data addr*16'h1111, then reads all -> each rsp1_rdata matches, no X on ram_data during any READ.
REQ-035 rst_n=0 at the edge ending READ for req1 -> no rsp1_valid, state IDLE, rsp1_rdata 0; next request served normally.
REQ-036 Bus check: RAM disconnected, read issued -> ram_data is Z throughout READ and IDLE, driven only during WRITE cycles.
